// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: decodes load/store requests, runs one req/ready
// bus transaction per instruction, aligns store lanes and extends load data.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic [2:0]        LoadOrStoreTYPE,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       StoreData,
  output logic              Stall,
  output logic [31:0]       LoadData,
  output logic              LoadValid,
  output logic              Fault,
  output logic              BusReq,
  output logic              BusWe,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [31:0]       BusWData,
  output logic [3:0]        BusByteEn,
  input  logic              BusReady,
  input  logic [31:0]       BusRData
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [2:0]       r_type;
  logic [1:0]       r_off;

  logic        w_req;
  logic        w_legal;
  logic        w_misal;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_load;

  // Request decode, legality, byte enables and store-lane replication
  always_comb begin
    w_req   = MemWrite | MemtoReg;
    w_off   = Addr[1:0];
    w_legal = 1'b0;
    w_misal = 1'b0;
    w_be    = 4'b1111;
    w_wdata = StoreData;
    if (MemWrite) begin
      w_legal = (LoadOrStoreTYPE == 3'b000) || (LoadOrStoreTYPE == 3'b001) ||
                (LoadOrStoreTYPE == 3'b010);
    end else begin
      w_legal = (LoadOrStoreTYPE == 3'b000) || (LoadOrStoreTYPE == 3'b001) ||
                (LoadOrStoreTYPE == 3'b010) || (LoadOrStoreTYPE == 3'b100) ||
                (LoadOrStoreTYPE == 3'b101);
    end
    case (LoadOrStoreTYPE[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{StoreData[7:0]}};
      end
      2'b01: begin
        w_misal = w_off[0];
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{StoreData[15:0]}};
      end
      default: begin
        w_misal = (w_off != 2'b00);
        w_be    = 4'b1111;
        w_wdata = StoreData;
      end
    endcase
  end

  // Lane extraction and sign/zero extension from the registered access type
  always_comb begin
    w_shift = BusRData >> {r_off, 3'b000};
    case (r_type)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load = {24'h000000, w_shift[7:0]};
      3'b101:  w_load = {16'h0000, w_shift[15:0]};
      default: w_load = BusRData;
    endcase
  end

  // Reset forces Stall low immediately, even with a request still presented
  assign Stall = !rst && (((r_state == IDLE) && w_req) || (r_state == BUSY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_type    <= 3'b000;
      r_off     <= 2'b00;
      LoadData  <= '0;
      LoadValid <= 1'b0;
      Fault     <= 1'b0;
      BusReq    <= 1'b0;
      BusWe     <= 1'b0;
      BusAddr   <= '0;
      BusWData  <= '0;
      BusByteEn <= 4'b0000;
    end else begin
      LoadValid <= 1'b0;
      Fault     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_legal && !w_misal) begin
              r_we      <= MemWrite;
              r_type    <= LoadOrStoreTYPE;
              r_off     <= w_off;
              r_cnt     <= '0;
              BusWe     <= MemWrite;
              BusAddr   <= {Addr[ADDR_W-1:2], 2'b00};
              BusByteEn <= w_be;
              BusWData  <= w_wdata;
              BusReq    <= 1'b1;
              r_state   <= BUSY;
            end else begin
              Fault   <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (BusReady) begin
            BusReq  <= 1'b0;
            r_state <= DONE;
            if (!r_we) begin
              LoadData  <= w_load;
              LoadValid <= 1'b1;
            end
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            BusReq  <= 1'b0;
            Fault   <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus queues expected bus/load/fault
// events, an independent monitor pops and compares them as the DUT produces them.
module tb_mem_access_ctrl;

  localparam int E_BUS   = 1;
  localparam int E_LOAD  = 2;
  localparam int E_FAULT = 3;

  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite, MemtoReg;
  logic [2:0]  LoadOrStoreTYPE;
  logic [31:0] Addr, StoreData;
  logic        Stall, LoadValid, Fault, BusReq, BusWe, BusReady;
  logic [31:0] LoadData, BusAddr, BusWData, BusRData;
  logic [3:0]  BusByteEn;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ready_delay = -1;
  int   wait_cnt = 0;
  int   busreq_cycles = 0;

  mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .LoadOrStoreTYPE(LoadOrStoreTYPE), .Addr(Addr), .StoreData(StoreData),
    .Stall(Stall), .LoadData(LoadData), .LoadValid(LoadValid), .Fault(Fault),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusWData(BusWData),
    .BusByteEn(BusByteEn), .BusReady(BusReady), .BusRData(BusRData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] data);
    exp_t e;
    e.kind = kind; e.we = we; e.addr = addr; e.be = be; e.data = data;
    exp_q.push_back(e);
  endtask

  // Bus slave: raises BusReady after ready_delay BusReq cycles (-1 = never)
  always @(posedge clk) begin
    #1;
    if (BusReq) begin
      BusReady = (ready_delay >= 0) && (wait_cnt == ready_delay);
      wait_cnt++;
      busreq_cycles++;
    end else begin
      BusReady = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (BusReq && BusReady) begin
        if (exp_q.size() == 0) chk("bus_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("bus_kind", e.kind, E_BUS);
          chk("bus_we", BusWe, e.we);
          chk("bus_addr", BusAddr, e.addr);
          chk("bus_be", BusByteEn, e.be);
          if (e.we) chk("bus_wdata", BusWData, e.data);
        end
      end
      if (LoadValid) begin
        if (exp_q.size() == 0) chk("load_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("load_kind", e.kind, E_LOAD);
          chk("load_data", LoadData, e.data);
        end
      end
      if (Fault) begin
        if (exp_q.size() == 0) chk("fault_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("fault_kind", e.kind, E_FAULT);
        end
      end
    end
  end

  // Present one instruction, hold it while stalled, check occupancy and bus cycles
  task automatic access(input string name, input logic w, input logic r,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int dly, input logic [31:0] rd,
                        input int exp_stall, input int exp_req);
    int n = 0;
    int req0;
    @(negedge clk);
    req0 = busreq_cycles;
    ready_delay = dly; BusRData = rd;
    MemWrite = w; MemtoReg = r; LoadOrStoreTYPE = f3; Addr = a; StoreData = sd;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!Stall) break;
      n++;
      @(negedge clk);
    end
    MemWrite = 1'b0; MemtoReg = 1'b0;
    chk({name, "_stall_cycles"}, n, exp_stall);
    chk({name, "_busreq_cycles"}, busreq_cycles - req0, exp_req);
  endtask

  initial begin
    rst = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; LoadOrStoreTYPE = 3'b000;
    Addr = '0; StoreData = '0; BusRData = '0; BusReady = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_stall", Stall, 0);
    chk("rst_busreq", BusReq, 0);
    chk("rst_buswe", BusWe, 0);
    chk("rst_busaddr", BusAddr, 0);
    chk("rst_buswdata", BusWData, 0);
    chk("rst_busbe", BusByteEn, 0);
    chk("rst_loaddata", LoadData, 0);
    chk("rst_loadvalid", LoadValid, 0);
    chk("rst_fault", Fault, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    push(E_BUS, 0, 32'h1000, 4'b1111, 0); push(E_LOAD, 0, 0, 0, 32'hDEADBEEF);
    access("lw", 0, 1, 3'b010, 32'h1000, 0, 2, 32'hDEADBEEF, 4, 3);

    push(E_BUS, 0, 32'h1000, 4'b1000, 0); push(E_LOAD, 0, 0, 0, 32'hFFFFFF80);
    access("lb", 0, 1, 3'b000, 32'h1003, 0, 0, 32'h80FF0000, 2, 1);
    push(E_BUS, 0, 32'h1000, 4'b1000, 0); push(E_LOAD, 0, 0, 0, 32'h00000080);
    access("lbu", 0, 1, 3'b100, 32'h1003, 0, 0, 32'h80FF0000, 2, 1);

    push(E_BUS, 1, 32'h2000, 4'b0100, 32'hA5A5A5A5);
    access("sb", 1, 0, 3'b000, 32'h2002, 32'h000000A5, 1, 0, 3, 2);
    push(E_BUS, 1, 32'h2000, 4'b1100, 32'h12341234);
    access("sh", 1, 0, 3'b001, 32'h2002, 32'h00001234, 0, 0, 2, 1);

    push(E_FAULT, 0, 0, 0, 0);
    access("lw_misal", 0, 1, 3'b010, 32'h1001, 0, 0, 0, 1, 0);
    push(E_FAULT, 0, 0, 0, 0);
    access("ld_f3_011", 0, 1, 3'b011, 32'h1000, 0, 0, 0, 1, 0);

    push(E_FAULT, 0, 0, 0, 0);
    access("timeout", 0, 1, 3'b010, 32'h3000, 0, -1, 0, 5, 4);

    push(E_BUS, 0, 32'h1000, 4'b1100, 0); push(E_LOAD, 0, 0, 0, 32'hFFFF8001);
    access("lh", 0, 1, 3'b001, 32'h1002, 0, 0, 32'h80011234, 2, 1);
    push(E_BUS, 0, 32'h1000, 4'b1100, 0); push(E_LOAD, 0, 0, 0, 32'h00008001);
    access("lhu", 0, 1, 3'b101, 32'h1002, 0, 1, 32'h80011234, 3, 2);

    push(E_BUS, 1, 32'h2004, 4'b1111, 32'hCAFEF00D);
    access("sw_both", 1, 1, 3'b010, 32'h2004, 32'hCAFEF00D, 0, 32'h55555555, 2, 1);
    chk("loaddata_hold", LoadData, 32'h00008001);

    push(E_FAULT, 0, 0, 0, 0);
    access("st_f3_100", 1, 0, 3'b100, 32'h2000, 0, 0, 0, 1, 0);

    // Reset in the middle of a stalled access
    @(negedge clk);
    ready_delay = -1;
    MemtoReg = 1'b1; LoadOrStoreTYPE = 3'b010; Addr = 32'h1000;
    repeat (3) @(negedge clk);
    chk("pre_rst_busreq", BusReq, 1);
    rst = 1'b1; MemtoReg = 1'b0;
    #1;
    chk("midrst_busreq", BusReq, 0);
    chk("midrst_stall", Stall, 0);
    @(negedge clk);
    rst = 1'b0;

    push(E_BUS, 0, 32'h1000, 4'b1111, 0); push(E_LOAD, 0, 0, 0, 32'h11223344);
    access("lw_after_rst", 0, 1, 3'b010, 32'h1000, 0, 0, 32'h11223344, 2, 1);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
